// File: rtl/rsa_pkg.sv
// Shared RSA datapath types and default widths.
package RSA_pkg;
    localparam int MOD_WIDTH = 256;
    localparam int INT_WIDTH = 32;

    typedef logic [MOD_WIDTH-1:0] KeyType;
    typedef logic [INT_WIDTH-1:0] IntType;

    typedef struct packed {
        IntType power;
        KeyType modulus;
    } TwoPowerIn;

    typedef KeyType TwoPowerOut;
endpackage

// File: rtl/mod_double_step.sv
// One modular doubling step: next_acc = (2*acc) mod modulus, given acc < modulus.
module mod_double_step #(
    parameter int MOD_WIDTH = RSA_pkg::MOD_WIDTH
) (
    input  logic [MOD_WIDTH-1:0] acc,
    input  logic [MOD_WIDTH-1:0] modulus,
    output logic [MOD_WIDTH-1:0] next_acc
);
    logic [MOD_WIDTH:0]   t;
    logic [MOD_WIDTH-1:0] diff;
    logic                 ge;

    assign t  = {acc, 1'b0};
    assign ge = (t >= {1'b0, modulus});
    // The true difference is below modulus, so the low bits alone are exact.
    assign diff = t[MOD_WIDTH-1:0] - modulus;

    always_comb begin
        next_acc = t[MOD_WIDTH-1:0];
        if (ge) begin
            next_acc = diff;
        end
    end
endmodule

// File: rtl/two_power_mod.sv
// Computes 2^power mod modulus by repeated modular doubling, one step per cycle.
// state | meaning
// IDLE  | waiting for a request, i_ready high
// CALC  | doubling acc until counter reaches zero
// DONE  | result presented, held until o_ready
module two_power_mod #(
    parameter int MOD_WIDTH = RSA_pkg::MOD_WIDTH,
    parameter int INT_WIDTH = RSA_pkg::INT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [INT_WIDTH+MOD_WIDTH-1:0] i_in,
    output logic                           o_valid,
    input  logic                           o_ready,
    output logic [MOD_WIDTH-1:0]           o_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [MOD_WIDTH-1:0] modulus;
    logic [MOD_WIDTH-1:0] acc;
    logic [MOD_WIDTH-1:0] next_acc;
    logic [INT_WIDTH-1:0] counter;
    logic [INT_WIDTH-1:0] in_power;
    logic [MOD_WIDTH-1:0] in_modulus;

    assign in_power   = i_in[INT_WIDTH+MOD_WIDTH-1:MOD_WIDTH];
    assign in_modulus = i_in[MOD_WIDTH-1:0];

    mod_double_step #(.MOD_WIDTH(MOD_WIDTH)) u_step (
        .acc      (acc),
        .modulus  (modulus),
        .next_acc (next_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            i_ready <= 1'b1;
            o_valid <= 1'b0;
            o_out   <= '0;
            acc     <= '0;
            counter <= '0;
            modulus <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && i_ready) begin
                        modulus <= in_modulus;
                        counter <= in_power;
                        acc     <= (in_modulus <= MOD_WIDTH'(1)) ? '0 : MOD_WIDTH'(1);
                        i_ready <= 1'b0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (counter != '0) begin
                        acc     <= next_acc;
                        counter <= counter - INT_WIDTH'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // o_valid rises one cycle after entering DONE, giving latency power+2.
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_out   <= acc;
                    end else if (o_ready) begin
                        o_valid <= 1'b0;
                        o_out   <= '0;
                        i_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    i_ready <= 1'b1;
                    o_valid <= 1'b0;
                    o_out   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_two_power_mod.sv
// Directed and randomized checks of two_power_mod against hand values and a shift/remainder model.
module tb_two_power_mod;
    localparam int MW = 256;
    localparam int IW = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_valid;
    logic           i_ready;
    logic [IW+MW-1:0] i_in;
    logic           o_valid;
    logic           o_ready;
    logic [MW-1:0]  o_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            power;
        logic [MW-1:0] modulus;
        logic [MW-1:0] exp_out;
        int            exp_lat;
    } vec_t;

    vec_t vecs[8];

    two_power_mod #(.MOD_WIDTH(MW), .INT_WIDTH(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_in    (i_in),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_out   (o_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW+MW-1:0] pack_req(input int power, input logic [MW-1:0] m);
        RSA_pkg::TwoPowerIn r;
        r.power   = power;
        r.modulus = m;
        return r;
    endfunction

    // Drive a request from a negedge and return once the accepting edge has passed.
    task automatic send(input int power, input logic [MW-1:0] m);
        int n;
        i_valid = 1'b1;
        i_in    = pack_req(power, m);
        n = 0;
        while (!i_ready && n < 1000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", MW'(n < 1000), MW'(1));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Wait for o_valid, check value and latency, stall, then complete the handshake.
    task automatic finish(input string name, input logic [MW-1:0] exp, input int exp_lat, input int stall);
        int lat;
        lat = 0;
        while (!o_valid && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, "_out"}, o_out, exp);
        chk({name, "_lat"}, MW'(lat), MW'(exp_lat));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_out"}, o_out, exp);
            chk({name, "_hold_valid"}, MW'(o_valid), MW'(1));
            chk({name, "_hold_ready"}, MW'(i_ready), MW'(0));
        end
        o_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        o_ready = 1'b0;
        chk({name, "_post_valid"}, MW'(o_valid), MW'(0));
        chk({name, "_post_iready"}, MW'(i_ready), MW'(1));
    endtask

    initial begin
        logic [MW-1:0] big_mod;
        logic [511:0]  pw;
        logic [MW-1:0] m;
        logic [MW-1:0] exp;
        int            p;
        int            seen;

        big_mod = '1;
        big_mod = big_mod - MW'(188);
        vecs[0] = '{0,   MW'(7),       MW'(1),    2};
        vecs[1] = '{10,  MW'(1000003), MW'(1024), 12};
        vecs[2] = '{5,   MW'(13),      MW'(6),    7};
        vecs[3] = '{256, big_mod,      MW'(189),  258};
        vecs[4] = '{4,   MW'(1),       MW'(0),    6};
        vecs[5] = '{3,   MW'(0),       MW'(0),    5};
        vecs[6] = '{1,   MW'(2),       MW'(0),    3};
        vecs[7] = '{8,   MW'(255),     MW'(1),    10};

        rst_n = 1'b0;
        i_valid = 1'b0;
        i_in = '0;
        o_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_iready", MW'(i_ready), MW'(1));
        chk("rst_ovalid", MW'(o_valid), MW'(0));
        chk("rst_oout", o_out, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].power, vecs[i].modulus);
            chk("calc_oout_zero", o_out, '0);
            finish($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_lat, 0);
        end

        // Stall with a competing request held on the input.
        send(5, MW'(13));
        i_valid = 1'b1;
        i_in = pack_req(2, MW'(7));
        finish("stall", MW'(6), 7, 10);
        chk("stall_second_pending", MW'(i_ready), MW'(1));
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        chk("stall_second_taken", MW'(i_ready), MW'(0));
        finish("stall2", MW'(4), 4, 0);

        // Reset mid-computation aborts with no result emitted.
        send(100, MW'(1000));
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ovalid", MW'(o_valid), MW'(0));
        chk("abort_iready", MW'(i_ready), MW'(1));
        chk("abort_oout", o_out, '0);
        seen = 0;
        repeat (150) begin
            @(posedge clk);
            @(negedge clk);
            if (o_valid) seen++;
        end
        chk("abort_no_result", MW'(seen), MW'(0));
        send(3, MW'(5));
        finish("after_rst", MW'(3), 5, 0);

        // Back-to-back random requests with random output stalls.
        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(0, 60);
            case ($urandom_range(0, 5))
                0: m = MW'($urandom_range(0, 1));
                1: m = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                default: m = MW'($urandom);
            endcase
            pw = 512'd1 << p;
            exp = (m <= MW'(1)) ? '0 : MW'(pw % {256'd0, m});
            send(p, m);
            finish($sformatf("rand%0d", i), exp, p + 2, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
